usb_system_cpu_cpu_oci_dct_ctrl: RTL and testbench

//  - Debug compressed-trace (DCT) controller for the Nios II OCI.
//  - Packs 2-bit trace atoms into a 30-bit DCT buffer with a 4-bit atom count.
//  - Emits completed 36-bit trace words to the on-chip trace RAM.
//  - Arbitrates that single RAM port between trace writes and JTAG host reads.
//  - Exposes dct_buffer/dct_count live for the OCI test-bench monitor.

---
 rtl/usb_system_cpu_oci_pkg.sv | 31 +++
 rtl/usb_system_cpu_cpu_oci_dct_ctrl_if.sv | 33 +++
 rtl/usb_system_cpu_cpu_oci_dct_packer.sv | 72 +++++++
 rtl/usb_system_cpu_cpu_oci_dct_ctrl.sv | 106 ++++++++++
 tb/tb_usb_system_cpu_cpu_oci_dct_ctrl.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/usb_system_cpu_oci_pkg.sv
// Shared OCI trace definitions: DCT buffer geometry, trace word layout and word-type codes.
package usb_system_cpu_oci_pkg;

    localparam int DCT_ATOMS  = 15;
    localparam int DCT_BUF_W  = 30;
    localparam int DCT_CNT_W  = 4;
    localparam int TRC_WORD_W = 36;

    typedef enum logic [1:0] {
        TYPE_NONE  = 2'b00,
        TYPE_FULL  = 2'b01,
        TYPE_FLUSH = 2'b10,
        TYPE_STOP  = 2'b11
    } word_type_e;

    typedef struct packed {
        word_type_e             wtype;
        logic [DCT_CNT_W-1:0]   count;
        logic [DCT_BUF_W-1:0]   buffer;
    } trc_word_t;

    // Deposit a 2-bit atom into its slot, selected by the current atom count
    function automatic logic [DCT_BUF_W-1:0] place_atom(
        input logic [DCT_BUF_W-1:0] cur,
        input logic [DCT_CNT_W-1:0] cnt,
        input logic [1:0]           atm
    );
        return cur | ({{(DCT_BUF_W-2){1'b0}}, atm} << {cnt, 1'b0});
    endfunction

endpackage

// File: rtl/usb_system_cpu_cpu_oci_dct_ctrl_if.sv
// Trace capture, host read and trace-RAM port bundle of the DCT controller.
interface usb_system_cpu_cpu_oci_dct_ctrl_if #(parameter int ADDR_W = 7);
    import usb_system_cpu_oci_pkg::*;

    logic                   trace_en;
    logic                   atom_vld;
    logic [1:0]             atom;
    logic                   flush;
    logic                   rd_req;
    logic [ADDR_W-1:0]      rd_addr;
    logic                   rd_grant;
    logic                   trc_we;
    logic [ADDR_W-1:0]      trc_addr;
    logic [TRC_WORD_W-1:0]  trc_wrdata;
    logic [ADDR_W-1:0]      wr_ptr;
    logic                   trc_wrap;
    logic                   overflow;
    logic [DCT_BUF_W-1:0]   dct_buffer;
    logic [DCT_CNT_W-1:0]   dct_count;

    modport master (
        output trace_en, atom_vld, atom, flush, rd_req, rd_addr,
        input  rd_grant, trc_we, trc_addr, trc_wrdata, wr_ptr, trc_wrap, overflow,
               dct_buffer, dct_count
    );

    modport slave (
        input  trace_en, atom_vld, atom, flush, rd_req, rd_addr,
        output rd_grant, trc_we, trc_addr, trc_wrdata, wr_ptr, trc_wrap, overflow,
               dct_buffer, dct_count
    );

endinterface

// File: rtl/usb_system_cpu_cpu_oci_dct_packer.sv
// Packs trace atoms into the DCT buffer and flags a completed word (full, flush or trace stop).
module usb_system_cpu_cpu_oci_dct_packer
    import usb_system_cpu_oci_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 trace_en,
    input  logic                 atom_vld,
    input  logic [1:0]           atom,
    input  logic                 flush,
    output logic                 word_vld,
    output trc_word_t            word,
    output logic [DCT_BUF_W-1:0] dct_buffer,
    output logic [DCT_CNT_W-1:0] dct_count
);

    logic                 trace_en_d;
    logic                 accept;
    logic                 full;
    logic                 flush_hit;
    logic                 stop_hit;
    logic [DCT_BUF_W-1:0] nxt_buffer;
    logic [DCT_CNT_W-1:0] nxt_count;

    // Buffer contents including this cycle's atom, and the word-completion causes
    always_comb begin
        accept     = trace_en & atom_vld;
        nxt_buffer = dct_buffer;
        nxt_count  = dct_count;
        if (accept) begin
            nxt_buffer = place_atom(dct_buffer, dct_count, atom);
            nxt_count  = dct_count + 4'd1;
        end else begin
            nxt_buffer = dct_buffer;
            nxt_count  = dct_count;
        end
        full      = accept && (dct_count == 4'd14);
        flush_hit = flush && (nxt_count != 4'd0);
        stop_hit  = trace_en_d && !trace_en && (dct_count != 4'd0);
        word_vld  = full | flush_hit | stop_hit;
        word.count  = nxt_count;
        word.buffer = nxt_buffer;
        if (full) begin
            word.wtype = TYPE_FULL;
        end else if (flush_hit) begin
            word.wtype = TYPE_FLUSH;
        end else if (stop_hit) begin
            word.wtype = TYPE_STOP;
        end else begin
            word.wtype = TYPE_NONE;
        end
    end

    // Packing state; an emitted word empties the buffer on the same edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trace_en_d <= 1'b0;
            dct_buffer <= '0;
            dct_count  <= 4'd0;
        end else begin
            trace_en_d <= trace_en;
            if (word_vld) begin
                dct_buffer <= '0;
                dct_count  <= 4'd0;
            end else begin
                dct_buffer <= nxt_buffer;
                dct_count  <= nxt_count;
            end
        end
    end

endmodule

// File: rtl/usb_system_cpu_cpu_oci_dct_ctrl.sv
// DCT controller top: pending word register, trace-RAM port arbiter, write pointer and sticky flags.
// Build option: define USB_SYSTEM_CPU_DCT_WRAP_EN to let the write pointer wrap instead of stopping when full.
module usb_system_cpu_cpu_oci_dct_ctrl
    import usb_system_cpu_oci_pkg::*;
#(
    parameter int ADDR_W = 7
) (
    input logic                            clk,
    input logic                            reset,
    usb_system_cpu_cpu_oci_dct_ctrl_if.slave bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic              word_vld;
    trc_word_t         word;
    logic              pending_vld;
    trc_word_t         pending_word;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic              ram_full;
    logic              wrap_flag;
    logic              ovf_flag;
    logic              do_write;
    logic              do_drop;

    usb_system_cpu_cpu_oci_dct_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .trace_en   (bus.trace_en),
        .atom_vld   (bus.atom_vld),
        .atom       (bus.atom),
        .flush      (bus.flush),
        .word_vld   (word_vld),
        .word       (word),
        .dct_buffer (bus.dct_buffer),
        .dct_count  (bus.dct_count)
    );

    assign do_write = pending_vld & ~ram_full;
    assign do_drop  = pending_vld & ram_full;

    // Pending word drains every cycle it is valid, so a new word can always load it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_vld  <= 1'b0;
            pending_word <= '0;
            wr_ptr_q     <= '0;
            ovf_flag     <= 1'b0;
        end else begin
            pending_vld  <= word_vld;
            pending_word <= word_vld ? word : '0;
            if (do_write) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_drop) begin
                ovf_flag <= 1'b1;
            end
        end
    end

`ifdef USB_SYSTEM_CPU_DCT_WRAP_EN
    assign ram_full = 1'b0;

    // Sticky wrap indication once the last address has been written
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrap_flag <= 1'b0;
        end else if (do_write && (wr_ptr_q == LAST_ADDR)) begin
            wrap_flag <= 1'b1;
        end
    end
`else
    assign wrap_flag = 1'b0;

    // RAM is full after the write to the last address; later words get dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_full <= 1'b0;
        end else if (do_write && (wr_ptr_q == LAST_ADDR)) begin
            ram_full <= 1'b1;
        end
    end
`endif

    // Single RAM port: a pending word owns the cycle, otherwise a host read is issued
    always_comb begin
        bus.trc_we     = do_write;
        bus.trc_wrdata = do_write ? pending_word : '0;
        bus.rd_grant   = 1'b0;
        bus.trc_addr   = '0;
        if (pending_vld) begin
            bus.trc_addr = wr_ptr_q;
        end else if (bus.rd_req) begin
            bus.rd_grant = 1'b1;
            bus.trc_addr = bus.rd_addr;
        end else begin
            bus.trc_addr = '0;
        end
    end

    assign bus.wr_ptr   = wr_ptr_q;
    assign bus.trc_wrap = wrap_flag;
    assign bus.overflow = ovf_flag;

endmodule

// File: tb/tb_usb_system_cpu_cpu_oci_dct_ctrl.sv
// Self-checking bench for the DCT controller: vector table with a write scoreboard, plus multi-cycle sequences.
module tb_usb_system_cpu_cpu_oci_dct_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    usb_system_cpu_cpu_oci_dct_ctrl_if #(.ADDR_W(7)) bus ();
    usb_system_cpu_cpu_oci_dct_ctrl_if #(.ADDR_W(2)) bus2 ();

    usb_system_cpu_cpu_oci_dct_ctrl #(.ADDR_W(7)) dut (.clk(clk), .reset(reset), .bus(bus));
    usb_system_cpu_cpu_oci_dct_ctrl #(.ADDR_W(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    typedef struct {
        bit          en;
        bit          vld;
        logic [1:0]  atom;
        bit          fl;
        bit          we;
        logic [35:0] word;
        logic [3:0]  cnt;
        logic [29:0] bufv;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [6:0]  addr;
        logic [35:0] data;
    } wr_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   wr2_cnt = 0;
    logic [1:0] last_addr2 = 2'd0;
    logic [6:0] next_addr = 7'd0;
    wr_t  exp_q[$];
    vec_t vt[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard: every write on the main instance must match the oldest expected one
    always @(negedge clk) begin
        if (!reset && bus.trc_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual addr=%0h data=%0h required=no write",
                         bus.trc_addr, bus.trc_wrdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_cycle", 64'(cyc), 64'(e.cyc));
                check("wr_addr", 64'(bus.trc_addr), 64'(e.addr));
                check("wr_data", 64'(bus.trc_wrdata), 64'(e.data));
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && bus2.trc_we) begin
            wr2_cnt++;
            last_addr2 = bus2.trc_addr;
        end
    end

    function automatic vec_t mk(input bit en, input bit vld, input logic [1:0] a, input bit fl,
                                input bit we, input logic [35:0] w, input logic [3:0] c,
                                input logic [29:0] b);
        vec_t v;
        v.en = en; v.vld = vld; v.atom = a; v.fl = fl;
        v.we = we; v.word = w; v.cnt = c; v.bufv = b;
        return v;
    endfunction

    task automatic apply(input bit en, input bit vld, input logic [1:0] a, input bit fl,
                         input bit we, input logic [35:0] w);
        wr_t e;
        #1;
        bus.trace_en = en;
        bus.atom_vld = vld;
        bus.atom     = a;
        bus.flush    = fl;
        if (we) begin
            e.cyc = cyc + 1;
            e.addr = next_addr;
            e.data = w;
            exp_q.push_back(e);
            next_addr = next_addr + 7'd1;
        end
        @(negedge clk);
    endtask

    task automatic check_idle(input string name);
        check({name, "_port"}, {bus.rd_grant, bus.trc_we, bus.trc_addr, bus.trc_wrdata, bus.wr_ptr,
                                bus.trc_wrap, bus.overflow}, 64'd0);
        check({name, "_dct"}, {bus.dct_buffer, bus.dct_count}, 64'd0);
    endtask

    initial begin
        logic [29:0] b;
        logic [35:0] w;
        logic [1:0]  a;
        vec_t        v;

        reset = 1'b1;
        bus.trace_en = 1'b0; bus.atom_vld = 1'b0; bus.atom = 2'b00; bus.flush = 1'b0;
        bus.rd_req = 1'b0; bus.rd_addr = 7'd0;
        bus2.trace_en = 1'b0; bus2.atom_vld = 1'b0; bus2.atom = 2'b00; bus2.flush = 1'b0;
        bus2.rd_req = 1'b0; bus2.rd_addr = 2'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle("reset");

        // 15 atoms 2'b10 complete a FULL word
        b = 30'd0;
        for (int i = 0; i < 14; i++) begin
            b = b | ({28'd0, 2'b10} << (2 * i));
            vt.push_back(mk(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 36'd0, 4'(i + 1), b));
        end
        w = {2'b01, 4'd15, 30'h2AAAAAAA};
        vt.push_back(mk(1'b1, 1'b1, 2'b10, 1'b0, 1'b1, w, 4'd0, 30'd0));
        // Three atoms then flush
        vt.push_back(mk(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 36'd0, 4'd1, 30'h1));
        vt.push_back(mk(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 36'd0, 4'd2, 30'hD));
        vt.push_back(mk(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 36'd0, 4'd3, 30'h2D));
        w = {2'b10, 4'd3, 24'd0, 6'b10_11_01};
        vt.push_back(mk(1'b1, 1'b0, 2'b00, 1'b1, 1'b1, w, 4'd0, 30'd0));
        // Flush on an empty buffer emits nothing; flush with a same-cycle atom includes it
        vt.push_back(mk(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 36'd0, 4'd0, 30'd0));
        w = {2'b10, 4'd1, 30'h3};
        vt.push_back(mk(1'b1, 1'b1, 2'b11, 1'b1, 1'b1, w, 4'd0, 30'd0));
        // trace_en falls at count 7
        b = 30'd0;
        for (int i = 0; i < 7; i++) begin
            a = 2'(i);
            b = b | ({28'd0, a} << (2 * i));
            vt.push_back(mk(1'b1, 1'b1, a, 1'b0, 1'b0, 36'd0, 4'(i + 1), b));
        end
        w = {2'b11, 4'd7, b};
        vt.push_back(mk(1'b0, 1'b0, 2'b00, 1'b0, 1'b1, w, 4'd0, 30'd0));
        vt.push_back(mk(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 36'd0, 4'd0, 30'd0));
        vt.push_back(mk(1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 36'd0, 4'd0, 30'd0));
        vt.push_back(mk(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 36'd0, 4'd0, 30'd0));

        for (int i = 0; i < vt.size(); i++) begin
            v = vt[i];
            apply(v.en, v.vld, v.atom, v.fl, v.we, v.word);
            check($sformatf("vec%0d_count", i), 64'(bus.dct_count), 64'(v.cnt));
            check($sformatf("vec%0d_buffer", i), 64'(bus.dct_buffer), 64'(v.bufv));
        end
        check("wr_ptr_after_table", 64'(bus.wr_ptr), 64'd4);

        // Host read coinciding with a pending write waits one cycle
        apply(1'b1, 1'b1, 2'b01, 1'b1, 1'b1, {2'b10, 4'd1, 30'h1});
        #1;
        bus.atom_vld = 1'b0; bus.flush = 1'b0;
        bus.rd_req = 1'b1; bus.rd_addr = 7'd5;
        #1;
        check("rd_cycle1_grant", 64'(bus.rd_grant), 64'd0);
        check("rd_cycle1_we", 64'(bus.trc_we), 64'd1);
        check("rd_cycle1_addr", 64'(bus.trc_addr), 64'd4);
        @(negedge clk);
        check("rd_cycle2_grant", 64'(bus.rd_grant), 64'd1);
        check("rd_cycle2_addr", 64'(bus.trc_addr), 64'd5);
        check("rd_cycle2_we", 64'(bus.trc_we), 64'd0);
        #1;
        bus.rd_req = 1'b0;
        @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        // Reset at count 9 while a word is completing: nothing is written
        for (int i = 0; i < 9; i++) begin
            apply(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 36'd0);
        end
        check("pre_reset_count", 64'(bus.dct_count), 64'd9);
        #1;
        bus.atom_vld = 1'b1; bus.flush = 1'b1;
        #2;
        reset = 1'b1;
        bus.atom_vld = 1'b0; bus.flush = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        next_addr = 7'd0;
        repeat (2) @(negedge clk);
        check_idle("post_reset");
        apply(1'b1, 1'b1, 2'b01, 1'b1, 1'b1, {2'b10, 4'd1, 30'h1});
        apply(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 36'd0);
        check("post_reset_wr_ptr", 64'(bus.wr_ptr), 64'd1);

        // Five flushed words into a 4-entry RAM
        for (int k = 0; k < 5; k++) begin
            #1;
            bus2.trace_en = 1'b1; bus2.atom_vld = 1'b1; bus2.atom = 2'b01; bus2.flush = 1'b1;
            @(negedge clk);
            if (k == 3) check("ram4_overflow_early", 64'(bus2.overflow), 64'd0);
        end
        #1;
        bus2.atom_vld = 1'b0; bus2.flush = 1'b0;
        repeat (2) @(negedge clk);
`ifdef USB_SYSTEM_CPU_DCT_WRAP_EN
        check("ram4_writes", 64'(wr2_cnt), 64'd5);
        check("ram4_last_addr", 64'(last_addr2), 64'd0);
        check("ram4_wrap", 64'(bus2.trc_wrap), 64'd1);
        check("ram4_overflow", 64'(bus2.overflow), 64'd0);
`else
        check("ram4_writes", 64'(wr2_cnt), 64'd4);
        check("ram4_last_addr", 64'(last_addr2), 64'd3);
        check("ram4_wrap", 64'(bus2.trc_wrap), 64'd0);
        check("ram4_overflow", 64'(bus2.overflow), 64'd1);
`endif

        @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
